// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_host_tx_pkg
// Purpose : Shared constants, FSM state encoding and the timer width helper
//           for the PS/2 host-to-device transmitter.
// Rev     : 1.0  initial release
// ============================================================================
package ps2_host_tx_pkg;

  // FSM state encoding
  typedef logic [1:0] ps2_tx_state_t;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_INHIBIT   = 2'd1;
  localparam logic [1:0] ST_REQ       = 2'd2;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd3;

  // Bit-counter positions inside the device-clocked frame
  localparam logic [3:0] PS2_TX_PAR_BIT  = 4'd8;
  localparam logic [3:0] PS2_TX_STOP_BIT = 4'd9;
  localparam logic [3:0] PS2_TX_ACK_BIT  = 4'd10;

  // Counter width able to hold (max(a,b) - 1); never narrower than one bit
  function automatic int ps2_tx_timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage : ps2_host_tx_pkg
`default_nettype wire

// File: rtl/ps2_tx_timer.sv
`default_nettype none
// ============================================================================
// Module  : ps2_tx_timer
// Purpose : Loadable down-counter with an expire flag. One instance serves
//           both the inhibit delay and the request-to-ACK timeout.
// Rev     : 1.0  initial release
// ============================================================================
module ps2_tx_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q;

  // Load has priority; the count saturates at zero
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule : ps2_tx_timer
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_host_tx
// Purpose : PS/2 host-to-device command transmitter. Inhibits the bus,
//           issues request-to-send, shifts 8 data bits LSB first plus odd
//           parity and stop on the device's falling clock edges, then samples
//           the device ACK. Drives open-drain enables only.
// Options : PS2_TX_RETRY_EN - one automatic retry after ACK error or timeout
// Rev     : 1.0  initial release
// ============================================================================
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic       valid_i,
  input  logic [7:0] dat_i,
  output logic       ready_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       timeout_o
);

  localparam int TW = ps2_tx_timer_width(INHIBIT_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Line synchronisers and falling-edge detect (idle lines are high)
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fe;

  if (SYNC_STAGES == 1) begin : g_sync_single
    // Single-flop capture of both pad inputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        clk_sync_q <= '1;
        dat_sync_q <= '1;
      end else begin
        clk_sync_q <= ps2_clk_i;
        dat_sync_q <= ps2_dat_i;
      end
    end
  end else begin : g_sync_chain
    // Multi-flop shift chain on both pad inputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        clk_sync_q <= '1;
        dat_sync_q <= '1;
      end else begin
        clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
        dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
      end
    end
  end

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // Previous synchronised clock for edge detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) clk_prev_q <= 1'b1;
    else          clk_prev_q <= clk_s;
  end

  assign fe = clk_prev_q & ~clk_s;

  // --------------------------------------------------------------------------
  // Shared timer
  // --------------------------------------------------------------------------
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_dec;
  logic          tmr_exp;

  ps2_tx_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .expired_o  (tmr_exp)
  );

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  ps2_tx_state_t state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          done_q, done_d;
  logic          ack_err_q, ack_err_d;
  logic          timeout_q, timeout_d;
  logic          rdy_en_q;
  logic          hs;

`ifdef PS2_TX_RETRY_EN
  logic          retry_q, retry_d;
  logic          retry_pend_q, retry_pend_d;
`endif

  assign ready_o = en_i & rdy_en_q & (state_q == ST_IDLE);
  assign hs      = valid_i & ready_o;

  // Next-state, line-drive and status-pulse decisions
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    par_d     = par_q;
    bitcnt_d  = bitcnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    ack_err_d = 1'b0;
    timeout_d = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = INH_LOAD;
    tmr_dec   = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d      = retry_q;
    retry_pend_d = retry_pend_q;
`endif

    case (state_q)
      ST_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d      = 1'b0;
        retry_pend_d = 1'b0;
`endif
        if (hs) begin
          sh_d     = dat_i;
          par_d    = ~^dat_i;
          clk_oe_d = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = INH_LOAD;
          state_d  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        tmr_dec = 1'b1;
        if (tmr_exp) begin
          // Release clock and drive the start bit in the same cycle
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMO_LOAD;
          bitcnt_d = 4'd0;
          state_d  = ST_REQ;
        end
      end

      ST_REQ: begin
        tmr_dec = 1'b1;
        if (fe && (bitcnt_q == PS2_TX_ACK_BIT)) begin
          // ACK sample outranks a coincident timeout
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = ST_WAIT_IDLE;
          if (!dat_s) begin
            done_d = 1'b1;
          end else begin
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
              retry_d      = 1'b1;
              retry_pend_d = 1'b1;
            end else begin
              ack_err_d = 1'b1;
            end
`else
            ack_err_d = 1'b1;
`endif
          end
        end else if (tmr_exp) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = ST_WAIT_IDLE;
`ifdef PS2_TX_RETRY_EN
          if (!retry_q) begin
            retry_d      = 1'b1;
            retry_pend_d = 1'b1;
          end else begin
            timeout_d = 1'b1;
          end
`else
          timeout_d = 1'b1;
`endif
        end else if (fe) begin
          if (bitcnt_q < PS2_TX_PAR_BIT) begin
            dat_oe_d = ~sh_q[bitcnt_q[2:0]];
          end else if (bitcnt_q == PS2_TX_PAR_BIT) begin
            dat_oe_d = ~par_q;
          end else begin
            dat_oe_d = 1'b0;  // stop bit: line released
          end
          bitcnt_d = bitcnt_q + 4'd1;
        end
      end

      ST_WAIT_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (clk_s && dat_s) begin
`ifdef PS2_TX_RETRY_EN
          if (retry_pend_q) begin
            retry_pend_d = 1'b0;
            clk_oe_d     = 1'b1;
            tmr_load     = 1'b1;
            tmr_val      = INH_LOAD;
            state_d      = ST_INHIBIT;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // Disable aborts silently from any active state
    if (!en_i && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      clk_oe_d  = 1'b0;
      dat_oe_d  = 1'b0;
      done_d    = 1'b0;
      ack_err_d = 1'b0;
      timeout_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_d      = 1'b0;
      retry_pend_d = 1'b0;
`endif
    end
  end

  // Control and output registers; reset releases both lines immediately
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      sh_q      <= 8'h00;
      par_q     <= 1'b0;
      bitcnt_q  <= 4'd0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      bitcnt_q  <= bitcnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
      rdy_en_q  <= 1'b1;
    end
  end

`ifdef PS2_TX_RETRY_EN
  // Retry bookkeeping: one extra attempt per accepted byte
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      retry_q      <= 1'b0;
      retry_pend_q <= 1'b0;
    end else begin
      retry_q      <= retry_d;
      retry_pend_q <= retry_pend_d;
    end
  end
`endif

  assign ps2_clk_oe_o = clk_oe_q;
  assign ps2_dat_oe_o = dat_oe_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign ack_err_o    = ack_err_q;
  assign timeout_o    = timeout_q;

endmodule : ps2_host_tx
`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to a keyboard over the open-drain PS/2 clock/data lines.
- Implements the standard sequence: inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, then device ACK.
- Sits beside the APB4 PS/2 receive path. The APB wrapper feeds it bytes via valid/ready, and the pad logic turns the *_oe_o outputs into open-drain pull-downs.

Parameters:
- INHIBIT_CYCLES, 10000, clk_i cycles that ps2_clk is held low before request-to-send (≥100 us; 10000 at 100 MHz).
- TIMEOUT_CYCLES, 2000000, clk_i cycles allowed from request-to-send to ACK sample (20 ms at 100 MHz).
- SYNC_STAGES, 2, synchroniser depth on ps2_clk_i/ps2_dat_i.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous reset, active low
- en_i  in  1  transmitter enable; low aborts any transfer
- valid_i  in  1  byte valid
- dat_i  in  8  byte to send
- ready_o  out  1  byte accepted when valid_i && ready_o
- ps2_clk_i  in  1  PS/2 clock line (pad input)
- ps2_dat_i  in  1  PS/2 data line (pad input)
- ps2_clk_oe_o  out  1  1 = pull clock line low
- ps2_dat_oe_o  out  1  1 = pull data line low
- busy_o  out  1  transfer in progress (state != IDLE)
- done_o  out  1  one-cycle pulse, transfer finished with valid ACK
- ack_err_o  out  1  one-cycle pulse, data line high at ACK sample
- timeout_o  out  1  one-cycle pulse, TIMEOUT_CYCLES expired

Behaviour:
- Reset values: all outputs 0. ready_o becomes 1 on the first cycle after reset only if en_i=1. Lines are released asynchronously on reset, including mid-transfer.
- Inputs pass through SYNC_STAGES flops. fe = falling edge of the synchronised ps2_clk.
- ready_o = en_i && state==IDLE.
- On handshake: latch dat_i into sh[7:0]; par = ~^dat_i (odd parity).
- State IDLE:
  - Both oe = 0.
  - Go to INHIBIT on handshake.
- State INHIBIT:
  - clk_oe = 1, dat_oe = 0.
  - Timer loaded with INHIBIT_CYCLES-1 and counts down.
  - At 0: dat_oe = 1 (start bit), clk_oe = 0 in the same cycle. Load timeout timer. Go to REQ with bitcnt = 0.
- State REQ, per fe (device clocks):
  - bitcnt 0..7: dat_oe = ~sh[bitcnt].
  - bitcnt 8: dat_oe = ~par.
  - bitcnt 9: dat_oe = 0 (stop bit, released).
  - bitcnt 10: sample synchronised ps2_dat_i. Value 0 pulses done_o; value 1 pulses ack_err_o. Go to WAIT_IDLE.
  - bitcnt increments on each fe. dat_oe holds between edges.
- State WAIT_IDLE:
  - Both oe = 0.
  - Go to IDLE when synchronised clk and dat are both 1.
  - done_o/ack_err_o pulse on the cycle of the ACK sample, not on exit.
- Timeout: timer decrements every cycle in REQ.
  - At 0: release both lines, pulse timeout_o, go to WAIT_IDLE.
  - If fe and expiry occur in the same cycle, the fe is processed first. If that fe is the ACK sample, done_o or ack_err_o wins and timeout_o is not pulsed.
- en_i low in any non-IDLE state: both oe = 0 next cycle, go to IDLE, no status pulse.
- fe during INHIBIT or WAIT_IDLE is ignored. valid_i is ignored while ready_o = 0.
- Latency: first bit driven at the first fe after REQ entry. The minimum handshake-to-REQ time is INHIBIT_CYCLES cycles.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- Defined: on ack_err or timeout, the block does not pulse the error immediately.
  - It waits for WAIT_IDLE to complete, then re-enters INHIBIT once with the latched byte.
  - The error pulse is issued only if the retry also fails; done_o is pulsed if the retry succeeds.
  - The retry flag clears on IDLE entry.
- Undefined: single attempt. Errors are reported immediately as described above.

Decomposition:
- ps2_define.sv additions: state typedef (IDLE, INHIBIT, REQ, WAIT_IDLE), bit-count constants PS2_TX_ACK_BIT = 10 and PS2_TX_STOP_BIT = 9.
- Reuse the existing edge_det_fe for sync plus falling-edge detect, and dffer for registers.
- One natural sub-module: ps2_tx_timer, a loadable down-counter with an expire flag. It is shared by INHIBIT and the timeout (width $clog2(TIMEOUT_CYCLES)).

Test Plan:
- Byte 0xED, device model clocking at 12.5 kHz and ACKing low:
  - ps2_clk_oe_o held high for exactly 10000 cycles, then start 0.
  - Data line after fe1..fe10: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done_o pulses once; ready_o returns after both lines are high.
- Byte 0x00: parity bit driven 1 (dat_oe = 0 at fe9); ACK high → ack_err_o pulse, no done_o.
- Byte 0xFF: device never clocks → timeout_o pulses at TIMEOUT_CYCLES after REQ entry; both oe = 0 the next cycle.
- en_i deasserted after fe4 → both oe = 0 in ≤1 cycle, no pulses, busy_o = 0. A new byte is accepted afterwards and completes.
- rst_n_i asserted mid-REQ → oe outputs are 0 immediately (asynchronous). After release, ready_o = 1 with en_i = 1.
- PS2_TX_RETRY_EN, byte 0xF4, first ACK high and second low → two INHIBIT phases, single done_o, no ack_err_o.
